riscv_ahb3lite_bus_arbiter: RTL and testbench
=============================================

// Module: riscv_ahb3lite_bus_arbiter
// PURPOSE
//  Merges the core's two AHB3-Lite master buses (ins_* from icache, dat_* from dcache) onto one
//  downstream AHB3-Lite master port (bus_*) for single-port SoCs. Sits directly downstream of the
//  cache bus interfaces. Holds a losing request in a per-port address register and stalls that
//  master via its HREADY. Fixed priority, burst/lock aware, zero added latency for the granted port.
// PARAMETERS
//  XLEN            32    data width of all three buses
//  PHYS_ADDR_SIZE  XLEN  address width of all three buses
//  HIGH_PRIO_PORT  1     port that wins simultaneous requests: 0=ins, 1=dat
// PORTS
//  HCLK            in   1     clock; all logic on rising edge
//  HRESET          in   1     asynchronous active-high reset
//  {ins,dat}_HSEL,_HWRITE,_HMASTLOCK  in  1 each    master address-phase controls
//  {ins,dat}_HADDR in   PHYS_ADDR_SIZE              master address
//  {ins,dat}_HSIZE,_HBURST in 3 each; _HPROT in 4; _HTRANS in 2   master transfer attributes
//  {ins,dat}_HWDATA in  XLEN  master write data (data phase)
//  {ins,dat}_HRDATA out XLEN  read data to master
//  {ins,dat}_HREADY out 1     transfer-done / stall to master
//  {ins,dat}_HRESP  out 1     response to master (0=OKAY,1=ERROR)
//  bus_HSEL,_HWRITE,_HMASTLOCK out 1 each; bus_HADDR out PHYS_ADDR_SIZE; bus_HSIZE,_HBURST out 3
//  bus_HPROT out 4; bus_HTRANS out 2; bus_HWDATA out XLEN    downstream address/data phase
//  bus_HRDATA in XLEN; bus_HREADY in 1; bus_HRESP in 1       downstream responses
// BEHAVIOUR
//  Per port p state: pend_p (captured address phase waiting), hold_p (captured signals), dph_p
//   (p owns the current downstream data phase); shared: owner (last granted port), lock flag.
//  Request: live_p = p_HSEL & p_HTRANS[1] & p_HREADY(out); req_p = pend_p | live_p.
//   IDLE never forwarded or captured; BUSY forwarded only from the locked owner.
//  Source of p = hold_p when pend_p else live p signals.
//  Grant (comb.): if lock -> owner; else HIGH_PRIO_PORT if its req, else other port if req, else none.
//   lock = owner's last accepted transfer had HMASTLOCK=1, or HBURST!=SINGLE and owner live HTRANS
//   is SEQ/BUSY. Lock never releases mid-burst or while HMASTLOCK=1.
//  bus_* address phase = source of granted port; no grant -> bus_HTRANS=IDLE, bus_HSEL=0, rest 0.
//  Edge with bus_HREADY=1: granted p: dph_p<=1, pend_p<=0, owner<=p; non-granted: dph<=0.
//  Any edge: live_p not accepted downstream this edge -> pend_p<=1, hold_p<=live signals.
//  p_HREADY = dph_p ? bus_HREADY : (pend_p ? 0 : 1). p_HRDATA/p_HRESP = bus_* when dph_p else 0.
//  bus_HWDATA = HWDATA of port with dph set (0 if none); masters hold HWDATA while stalled.
//  Both ERROR cycles of a 2-cycle bus_HRESP pass through unmodified to the dph port.
//  Latency: granted live request 0 extra cycles; losing/pended request +1 cycle minimum.
//  Simultaneous: live_p while dph_p and bus_HREADY=1 is normal pipelining; dph_p stays 1.
//  Starvation of low-priority port is accepted (core never streams both ports continuously).
//  Reset (async, any time, mid-transfer included): pend=0, dph=0, owner=HIGH_PRIO_PORT, lock=0;
//   outputs: ins/dat_HREADY=1, _HRDATA=0, _HRESP=0, bus_HTRANS=IDLE, bus_HSEL=0, all bus_* =0.
//   In-flight transfers are dropped; no replay after reset release.
// TESTING
//  1 Only ins NONSEQ 0x200 read, bus_HREADY=1 -> bus_HADDR=0x200 same cycle, ins_HREADY=1, data returned next cycle.
//  2 ins+dat NONSEQ same cycle (0x200, 0x8000 write) -> dat first; ins_HREADY=0 one cycle, ins 0x200 issued from hold next cycle.
//  3 ins INCR4 from 0x100 in flight, dat request at beat 2 -> beats 0x104..0x10C uninterrupted, dat issued after last beat.
//  4 dat HMASTLOCK=1 two transfers, ins requests meanwhile -> grant stays dat until HMASTLOCK=0 transfer accepted.
//  5 bus_HRESP=1 two cycles (HREADY 0 then 1) on dat read -> dat_HRESP=1 both cycles, ins_HRESP=0.
//  6 HRESET pulse while ins pended and dat in data phase -> all HREADY=1, bus_HTRANS=IDLE, nothing reissued.

Source files
------------

// File: rtl/riscv_ahb3lite_bus_arbiter.sv
// Two-into-one AHB3-Lite master arbiter: merges the icache (ins) and dcache (dat) master buses onto one
// downstream port with fixed priority, per-port address capture, and burst/lock-aware grant holding.
module riscv_ahb3lite_bus_arbiter #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned PHYS_ADDR_SIZE = XLEN,
    parameter int unsigned HIGH_PRIO_PORT = 1
) (
    input  logic                      HCLK,
    input  logic                      HRESET,

    input  logic                      ins_HSEL,
    input  logic [PHYS_ADDR_SIZE-1:0] ins_HADDR,
    input  logic [XLEN-1:0]           ins_HWDATA,
    output logic [XLEN-1:0]           ins_HRDATA,
    input  logic                      ins_HWRITE,
    input  logic [2:0]                ins_HSIZE,
    input  logic [2:0]                ins_HBURST,
    input  logic [3:0]                ins_HPROT,
    input  logic [1:0]                ins_HTRANS,
    input  logic                      ins_HMASTLOCK,
    output logic                      ins_HREADY,
    output logic                      ins_HRESP,

    input  logic                      dat_HSEL,
    input  logic [PHYS_ADDR_SIZE-1:0] dat_HADDR,
    input  logic [XLEN-1:0]           dat_HWDATA,
    output logic [XLEN-1:0]           dat_HRDATA,
    input  logic                      dat_HWRITE,
    input  logic [2:0]                dat_HSIZE,
    input  logic [2:0]                dat_HBURST,
    input  logic [3:0]                dat_HPROT,
    input  logic [1:0]                dat_HTRANS,
    input  logic                      dat_HMASTLOCK,
    output logic                      dat_HREADY,
    output logic                      dat_HRESP,

    output logic                      bus_HSEL,
    output logic [PHYS_ADDR_SIZE-1:0] bus_HADDR,
    output logic [XLEN-1:0]           bus_HWDATA,
    input  logic [XLEN-1:0]           bus_HRDATA,
    output logic                      bus_HWRITE,
    output logic [2:0]                bus_HSIZE,
    output logic [2:0]                bus_HBURST,
    output logic [3:0]                bus_HPROT,
    output logic [1:0]                bus_HTRANS,
    output logic                      bus_HMASTLOCK,
    input  logic                      bus_HREADY,
    input  logic                      bus_HRESP
);

    localparam int unsigned NPORT     = 2;
    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [2:0]  HBURST_SINGLE = 3'b000;
    localparam logic        HP = 1'(HIGH_PRIO_PORT);
    localparam logic        LP = ~HP;

    // Address-phase payload of one master; field order matches the concatenations below.
    typedef struct packed {
        logic                      sel;
        logic                      write;
        logic                      mastlock;
        logic [PHYS_ADDR_SIZE-1:0] addr;
        logic [2:0]                size;
        logic [2:0]                burst;
        logic [3:0]                prot;
        logic [1:0]                trans;
    } aph_t;

    aph_t [NPORT-1:0] live_aph;
    aph_t [NPORT-1:0] hold_q;
    aph_t [NPORT-1:0] src_aph;
    aph_t             gnt_aph;

    logic [NPORT-1:0] pend_q;
    logic [NPORT-1:0] dph_q;
    logic [NPORT-1:0] hready_c;
    logic [NPORT-1:0] live;
    logic [NPORT-1:0] req;
    logic [NPORT-1:0] gnt_oh;
    logic [NPORT-1:0] acc;
    logic [NPORT-1:0] pend_d;

    logic owner_q;
    logic lock_q;
    logic owner_burst;
    logic lock_c;
    logic gnt_vld;
    logic gnt_idx;

    assign live_aph[0] = {ins_HSEL, ins_HWRITE, ins_HMASTLOCK, ins_HADDR,
                          ins_HSIZE, ins_HBURST, ins_HPROT, ins_HTRANS};
    assign live_aph[1] = {dat_HSEL, dat_HWRITE, dat_HMASTLOCK, dat_HADDR,
                          dat_HSIZE, dat_HBURST, dat_HPROT, dat_HTRANS};

    // A master sees a stall while its captured request waits, else the downstream HREADY in its data phase.
    assign hready_c[0] = dph_q[0] ? bus_HREADY : ~pend_q[0];
    assign hready_c[1] = dph_q[1] ? bus_HREADY : ~pend_q[1];

    // Only NONSEQ/SEQ presented while the master believes it is being accepted count as new requests.
    assign live[0] = ~HRESET & live_aph[0].sel & live_aph[0].trans[1] & hready_c[0];
    assign live[1] = ~HRESET & live_aph[1].sel & live_aph[1].trans[1] & hready_c[1];
    assign req     = pend_q | live;

    assign src_aph[0] = pend_q[0] ? hold_q[0] : live_aph[0];
    assign src_aph[1] = pend_q[1] ? hold_q[1] : live_aph[1];

    // Owner keeps the bus through a locked sequence or while it is still walking a burst (SEQ/BUSY).
    assign owner_burst = live_aph[owner_q].sel
                       & (live_aph[owner_q].burst != HBURST_SINGLE)
                       & live_aph[owner_q].trans[0];
    assign lock_c      = ~HRESET & (lock_q | owner_burst);

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = HP;
        if (lock_c) begin
            gnt_vld = 1'b1;
            gnt_idx = owner_q;
        end else if (req[HP]) begin
            gnt_vld = 1'b1;
            gnt_idx = HP;
        end else if (req[LP]) begin
            gnt_vld = 1'b1;
            gnt_idx = LP;
        end
    end

    assign gnt_oh  = gnt_vld ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
    assign gnt_aph = gnt_vld ? src_aph[gnt_idx] : '0;
    assign acc     = live & gnt_oh & {NPORT{bus_HREADY}};

    // Capture whatever was presented but not taken; drop the capture once its grant completes.
    assign pend_d  = (pend_q | (live & ~acc)) & ~(gnt_oh & {NPORT{bus_HREADY}});

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pend_q  <= '0;
            dph_q   <= '0;
            owner_q <= HP;
            lock_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (bus_HREADY) begin
                dph_q <= gnt_oh;
                if (gnt_vld) begin
                    owner_q <= gnt_idx;
                    lock_q  <= gnt_aph.mastlock;
                end
            end
        end
    end

    for (genvar g = 0; g < NPORT; g++) begin : g_hold
        always_ff @(posedge HCLK or posedge HRESET) begin
            if (HRESET) begin
                hold_q[g] <= '0;
            end else if (live[g] && !acc[g]) begin
                hold_q[g] <= live_aph[g];
            end
        end
    end

    assign bus_HSEL      = gnt_aph.sel;
    assign bus_HWRITE    = gnt_aph.write;
    assign bus_HMASTLOCK = gnt_aph.mastlock;
    assign bus_HADDR     = gnt_aph.addr;
    assign bus_HSIZE     = gnt_aph.size;
    assign bus_HBURST    = gnt_aph.burst;
    assign bus_HPROT     = gnt_aph.prot;
    assign bus_HTRANS    = gnt_vld ? gnt_aph.trans : HTRANS_IDLE;

    // Write data follows whichever port owns the current data phase.
    assign bus_HWDATA = dph_q[1] ? dat_HWDATA :
                        dph_q[0] ? ins_HWDATA : '0;

    assign ins_HREADY = hready_c[0];
    assign dat_HREADY = hready_c[1];
    assign ins_HRDATA = dph_q[0] ? bus_HRDATA : '0;
    assign dat_HRDATA = dph_q[1] ? bus_HRDATA : '0;
    assign ins_HRESP  = dph_q[0] ? bus_HRESP  : 1'b0;
    assign dat_HRESP  = dph_q[1] ? bus_HRESP  : 1'b0;

endmodule

// File: tb/tb_riscv_ahb3lite_bus_arbiter.sv
// Scenario bench for riscv_ahb3lite_bus_arbiter: a queue of expected downstream transfers is filled as
// masters are driven and drained as the bus accepts address phases; per-cycle port checks are inline.
module tb_riscv_ahb3lite_bus_arbiter;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR4  = 3'b011;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        ins_HSEL, ins_HWRITE, ins_HMASTLOCK, ins_HREADY, ins_HRESP;
    logic [31:0] ins_HADDR, ins_HWDATA, ins_HRDATA;
    logic [2:0]  ins_HSIZE, ins_HBURST;
    logic [3:0]  ins_HPROT;
    logic [1:0]  ins_HTRANS;
    logic        dat_HSEL, dat_HWRITE, dat_HMASTLOCK, dat_HREADY, dat_HRESP;
    logic [31:0] dat_HADDR, dat_HWDATA, dat_HRDATA;
    logic [2:0]  dat_HSIZE, dat_HBURST;
    logic [3:0]  dat_HPROT;
    logic [1:0]  dat_HTRANS;
    logic        bus_HSEL, bus_HWRITE, bus_HMASTLOCK, bus_HREADY, bus_HRESP;
    logic [31:0] bus_HADDR, bus_HWDATA, bus_HRDATA;
    logic [2:0]  bus_HSIZE, bus_HBURST;
    logic [3:0]  bus_HPROT;
    logic [1:0]  bus_HTRANS;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
    } xfer_t;

    xfer_t exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    riscv_ahb3lite_bus_arbiter #(.XLEN(32), .PHYS_ADDR_SIZE(32), .HIGH_PRIO_PORT(1)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .ins_HSEL(ins_HSEL), .ins_HADDR(ins_HADDR), .ins_HWDATA(ins_HWDATA), .ins_HRDATA(ins_HRDATA),
        .ins_HWRITE(ins_HWRITE), .ins_HSIZE(ins_HSIZE), .ins_HBURST(ins_HBURST), .ins_HPROT(ins_HPROT),
        .ins_HTRANS(ins_HTRANS), .ins_HMASTLOCK(ins_HMASTLOCK), .ins_HREADY(ins_HREADY), .ins_HRESP(ins_HRESP),
        .dat_HSEL(dat_HSEL), .dat_HADDR(dat_HADDR), .dat_HWDATA(dat_HWDATA), .dat_HRDATA(dat_HRDATA),
        .dat_HWRITE(dat_HWRITE), .dat_HSIZE(dat_HSIZE), .dat_HBURST(dat_HBURST), .dat_HPROT(dat_HPROT),
        .dat_HTRANS(dat_HTRANS), .dat_HMASTLOCK(dat_HMASTLOCK), .dat_HREADY(dat_HREADY), .dat_HRESP(dat_HRESP),
        .bus_HSEL(bus_HSEL), .bus_HADDR(bus_HADDR), .bus_HWDATA(bus_HWDATA), .bus_HRDATA(bus_HRDATA),
        .bus_HWRITE(bus_HWRITE), .bus_HSIZE(bus_HSIZE), .bus_HBURST(bus_HBURST), .bus_HPROT(bus_HPROT),
        .bus_HTRANS(bus_HTRANS), .bus_HMASTLOCK(bus_HMASTLOCK), .bus_HREADY(bus_HREADY), .bus_HRESP(bus_HRESP)
    );

    task automatic drive_port(input logic p, input logic [1:0] trans, input logic [31:0] addr,
                              input logic write, input logic [2:0] burst, input logic lock);
        if (p == 1'b0) begin
            ins_HSEL = (trans != IDLE); ins_HTRANS = trans; ins_HADDR = addr; ins_HWRITE = write;
            ins_HBURST = burst; ins_HMASTLOCK = lock; ins_HSIZE = 3'b010; ins_HPROT = 4'b0011;
        end else begin
            dat_HSEL = (trans != IDLE); dat_HTRANS = trans; dat_HADDR = addr; dat_HWRITE = write;
            dat_HBURST = burst; dat_HMASTLOCK = lock; dat_HSIZE = 3'b010; dat_HPROT = 4'b0011;
        end
    endtask

    task automatic idle_all();
        drive_port(1'b0, IDLE, 32'h0, 1'b0, SINGLE, 1'b0);
        drive_port(1'b1, IDLE, 32'h0, 1'b0, SINGLE, 1'b0);
        ins_HWDATA = 32'h0; dat_HWDATA = 32'h0;
        bus_HREADY = 1'b1; bus_HRESP = 1'b0; bus_HRDATA = 32'h0;
    endtask

    task automatic expect_xfer(input logic [31:0] addr, input logic write);
        xfer_t e;
        e.addr = addr; e.write = write;
        exp_q.push_back(e);
    endtask

    // Called at the negedge: drains the scoreboard on an accepted downstream address phase, then steps.
    task automatic cycle_end();
        xfer_t e;
        if (bus_HTRANS[1] && bus_HREADY) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got addr=%h write=%0b required no transfer", bus_HADDR, bus_HWRITE);
            end else begin
                e = exp_q.pop_front();
                if (bus_HADDR !== e.addr || bus_HWRITE !== e.write) begin
                    errors++;
                    $display("FAIL sb_xfer got addr=%h write=%0b required addr=%h write=%0b",
                             bus_HADDR, bus_HWRITE, e.addr, e.write);
                end
            end
        end
        @(posedge HCLK); #1;
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_sb_empty got %0d outstanding required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge HCLK);
        checks++; if (ins_HREADY !== 1'b1) begin errors++; $display("FAIL rst_ins_hready got %b required 1", ins_HREADY); end
        checks++; if (dat_HREADY !== 1'b1) begin errors++; $display("FAIL rst_dat_hready got %b required 1", dat_HREADY); end
        checks++; if (bus_HTRANS !== IDLE) begin errors++; $display("FAIL rst_bus_htrans got %b required 00", bus_HTRANS); end
        checks++; if (bus_HSEL !== 1'b0 || bus_HADDR !== 32'h0) begin errors++; $display("FAIL rst_bus_addr got sel=%b addr=%h required 0", bus_HSEL, bus_HADDR); end
        checks++; if (ins_HRDATA !== 32'h0 || dat_HRESP !== 1'b0) begin errors++; $display("FAIL rst_resp got rdata=%h resp=%b required 0", ins_HRDATA, dat_HRESP); end
        @(posedge HCLK); #1;
        HRESET = 1'b0;
    endtask

    task automatic test_single();
        drive_port(1'b0, NONSEQ, 32'h200, 1'b0, SINGLE, 1'b0); expect_xfer(32'h200, 1'b0);
        @(negedge HCLK);
        checks++; if (bus_HADDR !== 32'h200) begin errors++; $display("FAIL t1_addr got %h required 200", bus_HADDR); end
        checks++; if (bus_HTRANS !== NONSEQ) begin errors++; $display("FAIL t1_trans got %b required 10", bus_HTRANS); end
        checks++; if (ins_HREADY !== 1'b1) begin errors++; $display("FAIL t1_ins_hready got %b required 1", ins_HREADY); end
        cycle_end();
        drive_port(1'b0, NONSEQ, 32'h204, 1'b0, SINGLE, 1'b0); expect_xfer(32'h204, 1'b0);
        bus_HRDATA = 32'hCAFE_0200;
        @(negedge HCLK);
        checks++; if (ins_HRDATA !== 32'hCAFE_0200) begin errors++; $display("FAIL t1_rdata0 got %h required cafe0200", ins_HRDATA); end
        checks++; if (bus_HADDR !== 32'h204 || ins_HREADY !== 1'b1) begin errors++; $display("FAIL t1_pipe got addr=%h rdy=%b required 204/1", bus_HADDR, ins_HREADY); end
        checks++; if (dat_HRDATA !== 32'h0) begin errors++; $display("FAIL t1_dat_rdata got %h required 0", dat_HRDATA); end
        cycle_end();
        drive_port(1'b0, IDLE, 32'h0, 1'b0, SINGLE, 1'b0);
        bus_HRDATA = 32'hCAFE_0204;
        @(negedge HCLK);
        checks++; if (ins_HRDATA !== 32'hCAFE_0204) begin errors++; $display("FAIL t1_rdata1 got %h required cafe0204", ins_HRDATA); end
        checks++; if (bus_HTRANS !== IDLE) begin errors++; $display("FAIL t1_idle got %b required 00", bus_HTRANS); end
        cycle_end();
        idle_all();
        check_sb_empty("t1");
    endtask

    task automatic test_collide();
        drive_port(1'b0, NONSEQ, 32'h200, 1'b0, SINGLE, 1'b0);
        drive_port(1'b1, NONSEQ, 32'h8000, 1'b1, SINGLE, 1'b0);
        expect_xfer(32'h8000, 1'b1); expect_xfer(32'h200, 1'b0);
        @(negedge HCLK);
        checks++; if (bus_HADDR !== 32'h8000 || bus_HWRITE !== 1'b1) begin errors++; $display("FAIL t2_dat_first got addr=%h w=%b required 8000/1", bus_HADDR, bus_HWRITE); end
        checks++; if (ins_HREADY !== 1'b1) begin errors++; $display("FAIL t2_ins_rdy0 got %b required 1", ins_HREADY); end
        cycle_end();
        drive_port(1'b0, IDLE, 32'h0, 1'b0, SINGLE, 1'b0);
        drive_port(1'b1, IDLE, 32'h0, 1'b0, SINGLE, 1'b0);
        dat_HWDATA = 32'h1234_5678; ins_HWDATA = 32'hDEAD_BEEF;
        @(negedge HCLK);
        checks++; if (ins_HREADY !== 1'b0) begin errors++; $display("FAIL t2_ins_stall got %b required 0", ins_HREADY); end
        checks++; if (bus_HADDR !== 32'h200 || bus_HTRANS !== NONSEQ) begin errors++; $display("FAIL t2_hold got addr=%h trans=%b required 200/10", bus_HADDR, bus_HTRANS); end
        checks++; if (bus_HWDATA !== 32'h1234_5678) begin errors++; $display("FAIL t2_wdata got %h required 12345678", bus_HWDATA); end
        checks++; if (dat_HREADY !== 1'b1) begin errors++; $display("FAIL t2_dat_rdy got %b required 1", dat_HREADY); end
        cycle_end();
        bus_HRDATA = 32'h5555_0200;
        @(negedge HCLK);
        checks++; if (ins_HREADY !== 1'b1 || ins_HRDATA !== 32'h5555_0200) begin errors++; $display("FAIL t2_ins_data got rdy=%b data=%h required 1/55550200", ins_HREADY, ins_HRDATA); end
        checks++; if (bus_HWDATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t2_wdata_ins got %h required deadbeef", bus_HWDATA); end
        cycle_end();
        idle_all();
        check_sb_empty("t2");
    endtask

    task automatic test_burst();
        drive_port(1'b0, NONSEQ, 32'h100, 1'b0, INCR4, 1'b0); expect_xfer(32'h100, 1'b0);
        @(negedge HCLK);
        checks++; if (bus_HADDR !== 32'h100) begin errors++; $display("FAIL t3_beat0 got %h required 100", bus_HADDR); end
        cycle_end();
        drive_port(1'b0, SEQ, 32'h104, 1'b0, INCR4, 1'b0); expect_xfer(32'h104, 1'b0);
        @(negedge HCLK);
        checks++; if (bus_HADDR !== 32'h104 || ins_HREADY !== 1'b1) begin errors++; $display("FAIL t3_beat1 got addr=%h rdy=%b required 104/1", bus_HADDR, ins_HREADY); end
        cycle_end();
        drive_port(1'b0, SEQ, 32'h108, 1'b0, INCR4, 1'b0); expect_xfer(32'h108, 1'b0);
        drive_port(1'b1, NONSEQ, 32'h8004, 1'b0, SINGLE, 1'b0);
        @(negedge HCLK);
        checks++; if (bus_HADDR !== 32'h108) begin errors++; $display("FAIL t3_beat2 got %h required 108", bus_HADDR); end
        checks++; if (dat_HREADY !== 1'b1) begin errors++; $display("FAIL t3_dat_rdy0 got %b required 1", dat_HREADY); end
        cycle_end();
        drive_port(1'b0, SEQ, 32'h10C, 1'b0, INCR4, 1'b0); expect_xfer(32'h10C, 1'b0);
        drive_port(1'b1, IDLE, 32'h0, 1'b0, SINGLE, 1'b0);
        @(negedge HCLK);
        checks++; if (bus_HADDR !== 32'h10C) begin errors++; $display("FAIL t3_beat3 got %h required 10c", bus_HADDR); end
        checks++; if (dat_HREADY !== 1'b0 || ins_HREADY !== 1'b1) begin errors++; $display("FAIL t3_rdy got dat=%b ins=%b required 0/1", dat_HREADY, ins_HREADY); end
        cycle_end();
        drive_port(1'b0, IDLE, 32'h0, 1'b0, SINGLE, 1'b0); expect_xfer(32'h8004, 1'b0);
        @(negedge HCLK);
        checks++; if (bus_HADDR !== 32'h8004 || bus_HTRANS !== NONSEQ) begin errors++; $display("FAIL t3_dat_issue got addr=%h trans=%b required 8004/10", bus_HADDR, bus_HTRANS); end
        cycle_end();
        @(negedge HCLK);
        checks++; if (dat_HREADY !== 1'b1) begin errors++; $display("FAIL t3_dat_done got %b required 1", dat_HREADY); end
        cycle_end();
        idle_all();
        check_sb_empty("t3");
    endtask

    task automatic test_lock();
        drive_port(1'b1, NONSEQ, 32'h9000, 1'b1, SINGLE, 1'b1); expect_xfer(32'h9000, 1'b1);
        @(negedge HCLK);
        checks++; if (bus_HMASTLOCK !== 1'b1 || bus_HADDR !== 32'h9000) begin errors++; $display("FAIL t4_lock0 got lk=%b addr=%h required 1/9000", bus_HMASTLOCK, bus_HADDR); end
        cycle_end();
        drive_port(1'b1, NONSEQ, 32'h9004, 1'b0, SINGLE, 1'b1); expect_xfer(32'h9004, 1'b0);
        drive_port(1'b0, NONSEQ, 32'h300, 1'b0, SINGLE, 1'b0);
        @(negedge HCLK);
        checks++; if (bus_HADDR !== 32'h9004) begin errors++; $display("FAIL t4_lock1 got %h required 9004", bus_HADDR); end
        cycle_end();
        drive_port(1'b1, IDLE, 32'h0, 1'b0, SINGLE, 1'b1);
        drive_port(1'b0, IDLE, 32'h0, 1'b0, SINGLE, 1'b0);
        @(negedge HCLK);
        checks++; if (bus_HTRANS !== IDLE || ins_HREADY !== 1'b0) begin errors++; $display("FAIL t4_held got trans=%b ins_rdy=%b required 00/0", bus_HTRANS, ins_HREADY); end
        cycle_end();
        drive_port(1'b1, NONSEQ, 32'h9008, 1'b0, SINGLE, 1'b0); expect_xfer(32'h9008, 1'b0);
        @(negedge HCLK);
        checks++; if (bus_HADDR !== 32'h9008 || ins_HREADY !== 1'b0) begin errors++; $display("FAIL t4_unlock got addr=%h ins_rdy=%b required 9008/0", bus_HADDR, ins_HREADY); end
        cycle_end();
        drive_port(1'b1, IDLE, 32'h0, 1'b0, SINGLE, 1'b0); expect_xfer(32'h300, 1'b0);
        @(negedge HCLK);
        checks++; if (bus_HADDR !== 32'h300 || bus_HTRANS !== NONSEQ) begin errors++; $display("FAIL t4_ins_issue got addr=%h trans=%b required 300/10", bus_HADDR, bus_HTRANS); end
        cycle_end();
        @(negedge HCLK);
        checks++; if (ins_HREADY !== 1'b1) begin errors++; $display("FAIL t4_ins_done got %b required 1", ins_HREADY); end
        cycle_end();
        idle_all();
        check_sb_empty("t4");
    endtask

    task automatic test_error();
        drive_port(1'b1, NONSEQ, 32'hA000, 1'b0, SINGLE, 1'b0); expect_xfer(32'hA000, 1'b0);
        @(negedge HCLK);
        cycle_end();
        drive_port(1'b1, IDLE, 32'h0, 1'b0, SINGLE, 1'b0);
        bus_HREADY = 1'b0; bus_HRESP = 1'b1;
        @(negedge HCLK);
        checks++; if (dat_HRESP !== 1'b1 || dat_HREADY !== 1'b0) begin errors++; $display("FAIL t5_err0 got resp=%b rdy=%b required 1/0", dat_HRESP, dat_HREADY); end
        checks++; if (ins_HRESP !== 1'b0 || ins_HREADY !== 1'b1) begin errors++; $display("FAIL t5_ins0 got resp=%b rdy=%b required 0/1", ins_HRESP, ins_HREADY); end
        cycle_end();
        bus_HREADY = 1'b1;
        @(negedge HCLK);
        checks++; if (dat_HRESP !== 1'b1 || dat_HREADY !== 1'b1) begin errors++; $display("FAIL t5_err1 got resp=%b rdy=%b required 1/1", dat_HRESP, dat_HREADY); end
        checks++; if (ins_HRESP !== 1'b0) begin errors++; $display("FAIL t5_ins1 got %b required 0", ins_HRESP); end
        cycle_end();
        idle_all();
        @(negedge HCLK);
        checks++; if (dat_HRESP !== 1'b0) begin errors++; $display("FAIL t5_clear got %b required 0", dat_HRESP); end
        cycle_end();
        check_sb_empty("t5");
    endtask

    task automatic test_reset_mid();
        drive_port(1'b0, NONSEQ, 32'h400, 1'b0, SINGLE, 1'b0);
        drive_port(1'b1, NONSEQ, 32'hB000, 1'b0, SINGLE, 1'b0); expect_xfer(32'hB000, 1'b0);
        @(negedge HCLK);
        cycle_end();
        drive_port(1'b0, IDLE, 32'h0, 1'b0, SINGLE, 1'b0);
        drive_port(1'b1, IDLE, 32'h0, 1'b0, SINGLE, 1'b0);
        bus_HREADY = 1'b0; bus_HRDATA = 32'h7777_7777;
        #1;
        checks++; if (ins_HREADY !== 1'b0 || dat_HRDATA !== 32'h7777_7777) begin errors++; $display("FAIL t6_pre got ins_rdy=%b dat_rdata=%h required 0/77777777", ins_HREADY, dat_HRDATA); end
        HRESET = 1'b1;
        @(negedge HCLK);
        checks++; if (ins_HREADY !== 1'b1 || dat_HREADY !== 1'b1) begin errors++; $display("FAIL t6_rdy got ins=%b dat=%b required 1/1", ins_HREADY, dat_HREADY); end
        checks++; if (bus_HTRANS !== IDLE || bus_HSEL !== 1'b0) begin errors++; $display("FAIL t6_bus got trans=%b sel=%b required 00/0", bus_HTRANS, bus_HSEL); end
        checks++; if (dat_HRDATA !== 32'h0 || dat_HRESP !== 1'b0) begin errors++; $display("FAIL t6_resp got rdata=%h resp=%b required 0/0", dat_HRDATA, dat_HRESP); end
        cycle_end();
        HRESET = 1'b0; bus_HREADY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge HCLK);
            checks++; if (bus_HTRANS !== IDLE || ins_HREADY !== 1'b1) begin errors++; $display("FAIL t6_noreplay got trans=%b ins_rdy=%b required 00/1", bus_HTRANS, ins_HREADY); end
            cycle_end();
        end
        idle_all();
        check_sb_empty("t6");
    endtask

    initial begin
        idle_all();
        repeat (2) @(posedge HCLK);
        #1;
        test_reset();
        test_single();
        test_collide();
        test_burst();
        test_lock();
        test_error();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
